// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, register-file write, issue and hazard-query signals of regfile_wb_arbiter.
// The arbiter uses the slave modport and its environment uses the master modport.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_wdata;
  logic                 rf_we;
  logic [AW-1:0]        rf_rd;
  logic [XLEN-1:0]      rf_wdata;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic [AW-1:0]        rs1;
  logic [AW-1:0]        rs2;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [AW:0]          pending_cnt;

  modport slave (
    input  req_valid, req_rd, req_wdata, issue_valid, issue_rd, rs1, rs2,
    output req_ready, rf_we, rf_rd, rf_wdata, rs1_busy, rs2_busy, pending_cnt
  );

  modport master (
    output req_valid, req_rd, req_wdata, issue_valid, issue_rd, rs1, rs2,
    input  req_ready, rf_we, rf_rd, rf_wdata, rs1_busy, rs2_busy, pending_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ sources (1-cycle accept-to-write, no output stall)
// and tracks pending destination registers; WB_ARB_RR_EN selects round-robin over fixed priority.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int IW   = (NREQ > 2) ? 2 : 1;
  localparam int NREG = 1 << AW;

  logic [IW-1:0]   gidx;
  logic            gany;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] grant;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_wdata;

  logic            we_q;
  logic [AW-1:0]   rd_q;
  logic [XLEN-1:0] wdata_q;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     cnt_q;
  logic [AW:0]     cnt_nxt;

`ifdef WB_ARB_RR_EN
  logic [IW-1:0] ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gany) begin
      ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
    end
  end
`else
  localparam logic [IW-1:0] ptr = '0;
`endif

  // Walk the candidates from the farthest to the nearest so the last hit is the one closest to ptr.
  always_comb begin
    gany = 1'b0;
    gidx = '0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (bus.req_valid[cand]) begin
        gany = 1'b1;
        gidx = cand;
      end
    end
  end

  assign grant         = gany ? (NREQ'(1) << gidx) : '0;
  assign bus.req_ready = rst ? '0 : grant;
  assign sel_rd        = bus.req_rd[int'(gidx)*AW +: AW];
  assign sel_wdata     = bus.req_wdata[int'(gidx)*XLEN +: XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else if (gany) begin
      we_q    <= (sel_rd != '0);
      rd_q    <= sel_rd;
      wdata_q <= sel_wdata;
    end else begin
      we_q    <= 1'b0;
    end
  end

  // Issue set is applied after the writeback clear so a same-register collision stays pending.
  always_comb begin
    pend_nxt = pending;
    if (we_q) begin
      pend_nxt[rd_q] = 1'b0;
    end
    if (bus.issue_valid) begin
      pend_nxt[bus.issue_rd] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[r]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      cnt_q   <= '0;
    end else begin
      pending <= pend_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign bus.rf_we       = we_q;
  assign bus.rf_rd       = rd_q;
  assign bus.rf_wdata    = wdata_q;
  assign bus.rs1_busy    = pending[bus.rs1];
  assign bus.rs2_busy    = pending[bus.rs2];
  assign bus.pending_cnt = cnt_q;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (rd/wdata/we) among NREQ writeback sources, e.g. ALU, load unit and mul/div.
- Holds a per-register pending scoreboard so issue logic can stall on RAW hazards.
- Sits between the execute/memory writeback sources and the 32x32 register file; x0 is never written and never reported busy.

Parameters:
- NREQ, 3, number of writeback requesters; legal range 2..4.
- XLEN, 32, data width.
- AW, 5, register address width (32 registers).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NREQ  per-requester writeback valid
- req_ready  out  NREQ  per-requester grant; transfer occurs when valid&ready
- req_rd  in  NREQ*AW  packed destination addresses; requester i at [i*AW +: AW]
- req_wdata  in  NREQ*XLEN  packed write data; requester i at [i*XLEN +: XLEN]
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  AW  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- issue_valid  in  1  an instruction issuing this cycle will write issue_rd
- issue_rd  in  AW  destination register of the issuing instruction
- rs1  in  AW  hazard query address 1
- rs2  in  AW  hazard query address 2
- rs1_busy  out  1  rs1 has an outstanding write
- rs2_busy  out  1  rs2 has an outstanding write
- pending_cnt  out  AW+1  number of registers currently marked pending (registered)

Behaviour:
- Reset is async, active-high: rst asynchronous, active-high; clock clk. Reset clears rf_we=0, rf_rd=0, rf_wdata=0, pending[31:0]=0, pending_cnt=0 and the priority pointer to 0. req_ready is forced to 0 while rst is high.
- Arbitration (combinational): at most one req_ready bit high per cycle, and only for a requester with req_valid=1. req_ready never asserts without the matching valid. No grant when all valid bits are low.
- Output stage: on a transfer from requester g, at the next posedge rf_we<=(req_rd[g]!=0), rf_rd<=req_rd[g], rf_wdata<=req_wdata[g]. Without a transfer, rf_we<=0 and rf_rd/rf_wdata hold their values.
- Latency: exactly 1 cycle from accept to rf_we. The register file always accepts writes, so there is no output backpressure. Throughput is 1 write per cycle.
- rd==0 request: accepted normally and consumes the grant, but produces no write (rf_we=0) and no scoreboard change.
- Scoreboard, per bit r in 1..31, updated at each posedge:
  - set when issue_valid && issue_rd==r;
  - else clear when rf_we && rf_rd==r.
  - Set and clear to the same r in one cycle: set wins.
  - pending[0] is constantly 0; issue_rd==0 is ignored.
- Busy outputs: rsN_busy = pending[rsN] (combinational; 0 for rsN==0). Busy drops in the cycle after rf_we, which is the same edge at which the register file captures the data, so a read is valid once busy is low.
- pending_cnt: registered popcount of the next-state pending vector, so it always equals popcount(pending). Range 0..31.
- Issue logic must not issue a second writer to a register that is still pending. The block does not check this; if it happens, the bit stays set until the first write lands.
- Reset mid-operation: an in-flight output-stage write is dropped (rf_we=0) and all pending bits are lost.

Optional Feature:
- Macro: WB_ARB_RR_EN.
- Defined: round-robin arbitration. Search starts at the pointer p (0..NREQ-1). After each transfer, p<=(g+1) mod NREQ. p holds when there is no transfer.
- Undefined: fixed priority, with lowest index winning (req0>req1>req2). No pointer register is built.

Test Plan:
- Reset then single write: req_valid=3'b001, rd=5, wdata=0xDEADBEEF. Expect req_ready=001 in the same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; the cycle after, rf_we=0.
- Contention, all three valid for 6 cycles with fixed rd=1/2/3:
  - RR_EN defined: grant sequence 0,1,2,0,1,2.
  - RR_EN undefined: grant 0 every cycle; req1 and req2 stall until req0 drops.
- Scoreboard: issue_valid with issue_rd=7 -> next cycle rs1=7 gives rs1_busy=1 and pending_cnt=1. After the requester writes rd=7, rs1_busy=0 and pending_cnt=0 in the cycle after rf_we.
- Simultaneous set/clear: rf_we=1 with rf_rd=9 while issue_valid with issue_rd=9 in the same cycle -> pending[9] stays 1 and pending_cnt is unchanged.
- x0 handling: request with rd=0 is granted with rf_we=0 next cycle. issue_rd=0 leaves pending_cnt=0. rs2=0 gives rs2_busy=0 always.
- Async reset mid-flight: assert rst between accept and output with 4 registers pending -> rf_we=0 and req_ready=0 immediately, pending_cnt=0, busy outputs 0. After release, arbitration restarts from pointer 0.
